// File: rtl/mantissa_multiplier_pkg.sv
// Shared constants and Dadda height helpers for the
// significand multiplier's carry-save reduction tree.
package fp_mant_pkg;

  localparam int MANT_W_HALF   = 11;
  localparam int MANT_W_SINGLE = 24;

  function automatic int dadda_height(input int j);
    int d;
    d = 2;
    for (int k = 0; k < j; k++) d = (d * 3) / 2;
    return d;
  endfunction

  function automatic int dadda_stages(input int n);
    int s;
    s = 0;
    while (dadda_height(s) < n) s++;
    return s;
  endfunction

  // Row count entering stage st; st == stages gives the final 2 rows
  function automatic int stage_height(input int n, input int st);
    int t;
    t = dadda_stages(n);
    if (st == 0) return n;
    return dadda_height(t - st);
  endfunction

endpackage

// File: rtl/mantissa_multiplier_full_adder.sv
// One-bit full adder, the 3:2 cell of the
// multiplier's carry-save reduction tree.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/mantissa_multiplier.sv
// Exact unsigned N x N significand multiplier: AND array,
// Dadda-height carry-save tree, final CPA, one output register.
module mantissa_multiplier
  import fp_mant_pkg::*;
#(
  parameter int N = MANT_W_HALF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  input  logic           in_valid,
  output logic [2*N-1:0] result,
  output logic           out_valid
);

  localparam int W   = 2 * N;
  localparam int STG = dadda_stages(N);

  logic [W-1:0] w_pp [N];
  logic [W-1:0] w_fa;
  logic [W-1:0] w_fb;
  logic [W-1:0] prod_comb;
  logic [W-1:0] r_result;
  logic         r_valid;

  for (genvar i = 0; i < N; i++) begin : g_pp
    assign w_pp[i] = {{N{1'b0}}, A & {N{B[i]}}} << i;
  end

  // Each stage applies just enough row compressors to hit
  // the next lower Dadda height; leftover rows pass through.
  for (genvar s = 0; s < STG; s++) begin : g_st
    localparam int HI = stage_height(N, s);
    localparam int HO = stage_height(N, s + 1);
    localparam int NC = HI - HO;
    localparam int NP = HI - 3 * NC;

    logic [W-1:0] w_in  [HI];
    logic [W-1:0] w_out [HO];

    for (genvar r = 0; r < HI; r++) begin : g_src
      if (s == 0) begin : g_first
        assign w_in[r] = w_pp[r];
      end else begin : g_next
        assign w_in[r] = g_st[s-1].w_out[r];
      end
    end

    for (genvar c = 0; c < NC; c++) begin : g_csa
      logic [W-1:0] w_s;
      logic [W-2:0] w_c;
      for (genvar b = 0; b < W - 1; b++) begin : g_bit
        full_adder u_fa (
          .a    (w_in[3*c][b]),
          .b    (w_in[3*c+1][b]),
          .cin  (w_in[3*c+2][b]),
          .s    (w_s[b]),
          .cout (w_c[b])
        );
      end
      // Top carry falls off the 2N-bit range; product never needs it
      assign w_s[W-1] = w_in[3*c][W-1] ^ w_in[3*c+1][W-1]
                      ^ w_in[3*c+2][W-1];
      assign w_out[2*c]   = w_s;
      assign w_out[2*c+1] = {w_c, 1'b0};
    end

    for (genvar p = 0; p < NP; p++) begin : g_pass
      assign w_out[2*NC+p] = w_in[3*NC+p];
    end
  end

  if (STG == 0) begin : g_fin0
    assign w_fa = w_pp[0];
    assign w_fb = w_pp[1];
  end else begin : g_fin
    assign w_fa = g_st[STG-1].w_out[0];
    assign w_fb = g_st[STG-1].w_out[1];
  end

  assign prod_comb = w_fa + w_fb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) r_result <= prod_comb;
    end
  end

  assign result    = r_result;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_mantissa_multiplier.sv
// Scoreboarded random and directed bench for mantissa_multiplier.
// Driver queues expectations; monitor pops one per clock.
module tb_mantissa_multiplier;

  localparam int N = 11;
  localparam int W = 2 * N;

  typedef struct packed {
    logic         v;
    logic [W-1:0] r;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] result;
  logic         out_valid;

  exp_t         q[$];
  logic [W-1:0] m_last = '0;
  int           checks = 0;
  int           errors = 0;
  bit           done = 1'b0;

  mantissa_multiplier #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .result    (result),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic v,
                      input logic [N-1:0] a, input logic [N-1:0] b,
                      input bit fix, input logic [W-1:0] fexp);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r;
    in_valid = v;
    A = a;
    B = b;
    if (r) begin
      m_last = '0;
      e.v = 1'b0;
    end else begin
      e.v = v;
      if (v) m_last = fix ? fexp
                          : ({{N{1'b0}}, a} * {{N{1'b0}}, b});
    end
    e.r = m_last;
    q.push_back(e);
  endtask

  task automatic dir(input logic v, input logic [N-1:0] a,
                     input logic [N-1:0] b, input logic [W-1:0] x);
    step(1'b0, v, a, b, 1'b1, x);
  endtask

  task automatic rnd(input logic v, input logic [N-1:0] a,
                     input logic [N-1:0] b);
    step(1'b0, v, a, b, 1'b0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (out_valid !== e.v) begin
          errors++;
          $display("FAIL out_valid t=%0t got=%b want=%b",
                   $time, out_valid, e.v);
        end
        checks++;
        if (result !== e.r) begin
          errors++;
          $display("FAIL result t=%0t got=%h want=%h",
                   $time, result, e.r);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    if (!done) begin
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
    end
  end

  initial begin : driver
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         v;
    logic         xa;

    step(1'b1, 1'b1, 11'd3, 11'd5, 1'b1, '0);
    step(1'b1, 1'b1, 11'd3, 11'd5, 1'b1, '0);
    dir(1'b1, 11'd3, 11'd5, 22'd15);
    dir(1'b1, 11'h400, 11'h400, 22'h100000);
    dir(1'b1, 11'h7FF, 11'h7FF, 22'h3FF001);
    dir(1'b1, 11'h000, 11'h5A5, 22'h000000);
    dir(1'b1, 11'h001, 11'h5A5, 22'h0005A5);
    dir(1'b1, 11'h5A5, 11'h001, 22'h0005A5);
    dir(1'b1, 11'd2, 11'd3, 22'd6);
    dir(1'b1, 11'd7, 11'd9, 22'd63);
    dir(1'b1, 11'd100, 11'd200, 22'd20000);
    xa = 1'bx;
    dir(1'b0, {N{xa}}, {N{xa}}, '0);
    dir(1'b0, 11'h7FF, 11'h7FF, '0);
    dir(1'b1, 11'h7FF, 11'h7FF, 22'h3FF001);
    step(1'b1, 1'b1, 11'h123, 11'h456, 1'b1, '0);
    dir(1'b0, 11'd0, 11'd0, '0);
    dir(1'b1, 11'd3, 11'd5, 22'd15);

    for (int i = 0; i < 10000; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      case ($urandom_range(0, 7))
        0: a = '1;
        1: b = '1;
        2: a = 11'h400;
        default: ;
      endcase
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0)
        step(1'b1, v, a, b, 1'b0, '0);
      else
        rnd(v, a, b);
    end

    dir(1'b0, 11'd0, 11'd0, '0);
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mantissa_multiplier.md
Name: mantissa_multiplier

Overview:
Unsigned fixed-width mantissa multiplier for the FP datapath.
- Takes two N-bit significands, hidden bit included (N=11 for half precision).
- Produces the exact 2N-bit product, with no rounding or normalisation; downstream FP logic handles both.
- One registered output stage. Sits between operand unpacking and normalise/round.

Parameters:
N, 11, significand width in bits including hidden bit; legal range 2..32

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
A  input  N  unsigned multiplicand
B  input  N  unsigned multiplier
in_valid  input  1  A/B qualified this cycle
result  output  2N  registered unsigned product A*B
out_valid  output  1  result qualified this cycle

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst. All state updates on posedge clk.
- Reset: when rst=1 at a posedge, the block sets result <= 0 and out_valid <= 0. Reset overrides in_valid in the same cycle.
- Arithmetic: result = A*B, unsigned, full 2N bits, exact; overflow is impossible.
- Maximum product is (2^N-1)^2, which fits in 2N bits.
- Structure: combinational partial-product array (N rows of N AND terms), reduced by a Dadda/Wallace carry-save tree, then one final 2N-bit carry-propagate adder. Result register at the output.
- Latency: exactly 1 cycle. Operands sampled at edge k with in_valid=1 give result and out_valid=1 after edge k.
- Throughput: one operation per cycle, no stalls, no backpressure.
- out_valid <= in_valid every non-reset cycle.
- result loads only when in_valid=1 and holds its previous value otherwise, so a consumer may sample it late.
- Combinational path: the unregistered product is also available internally as prod_comb, for wrappers that sample in the same cycle. Not a port.
- X handling: in_valid=0 with X on A/B must not disturb result.
- Reset mid-operation: any product in flight is discarded; the first valid after reset release is handled normally.

Decomposition:
- Package fp_mant_pkg holds:
  - localparam MANT_W_HALF=11, MANT_W_SINGLE=24
  - a function computing the Dadda stage height sequence for a given N
- Sub-module full_adder (a, b, cin -> s, cout), used throughout the reduction tree.
- A half adder may be inline logic.
- The top-level generate loops build the partial products and the tree.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, A=3, B=5 -> result=0, out_valid=0. First cycle after release with same inputs -> next cycle result=15, out_valid=1.
- Hidden-bit operands, N=11: A=11'h400, B=11'h400 -> result=22'h100000 one cycle later.
- Maximum operands, N=11: A=B=11'h7FF -> result=22'h3FF001 (4190209).
- Identity/zero: A=0, B=11'h5A5 -> 0. A=1, B=11'h5A5 -> 22'h0005A5. A=11'h5A5, B=1 -> 22'h0005A5.
- Back-to-back throughput: in_valid=1 for 3 cycles with (2,3), (7,9), (100,200). Results appear in consecutive cycles: 6, 63, 20000. Then in_valid=0 -> out_valid=0, result holds 20000.
- Randomised plus reset mid-stream: 10k random A/B pairs compared to a reference A*B. Assert rst mid-stream -> the pending result is discarded, and outputs are 0 the cycle after reset.
